// File: rtl/iter_divider_pkg.sv
// Shared types for the iterative divider: FSM states, operand mux select,
// a one-bit boolean type and a helper producing the most-negative value.
package divider3Pkg;

    typedef logic bool_t;

    typedef enum logic [2:0] {
        IDLE,
        PREP,
        ITER,
        FIX,
        DONE
    } state_t;

    typedef enum logic {
        OPER_IN,
        NEG_OPER_IN
    } oper_sel_t;

    localparam int MAX_WIDTH = 64;

    // Two's-complement minimum for a given width, returned right-aligned in 64 bits.
    function automatic logic [MAX_WIDTH-1:0] min_val(input int width);
        return MAX_WIDTH'(1) << (width - 1);
    endfunction

endpackage

// File: rtl/div_operand_reg.sv
// Operand register: loads its input either as-is or negated when enabled.
// The divider uses it to capture a raw operand, then to turn it into a magnitude,
// and (for the dividend) as the quotient shift register.
module div_operand_reg
    import divider3Pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             clear_n,
    input  logic             en,
    input  oper_sel_t        sel,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] q
);

    // Registered load of the selected (pass-through or negated) input.
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            q <= '0;
        end else if (en) begin
            q <= (sel == NEG_OPER_IN) ? -din : din;
        end
    end

endmodule

// File: rtl/iter_divider.sv
// Multi-cycle restoring divider, signed or unsigned, one quotient bit per cycle.
//
// state | meaning
// IDLE  | ready for operands
// PREP  | raw operands held; form magnitudes, detect divide-by-zero / MIN/-1
// ITER  | one shift/trial-subtract step per cycle, WIDTH cycles
// FIX   | apply signs to quotient and remainder
// DONE  | result valid, held until the consumer accepts it
module iter_divider
    import divider3Pkg::*;
#(
    parameter  int WIDTH = 32,
    localparam int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             resetN,
    input  logic             inValid,
    output logic             inReady,
    input  logic             signedOp,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             flush,
    output logic             outValid,
    input  logic             outReady,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             divZero,
    output logic             overflow
);

    localparam logic [WIDTH-1:0] MIN_VAL = WIDTH'(min_val(WIDTH));

    state_t           state, state_nxt;
    bool_t            sign_mode, q_neg, r_neg;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] rem_w;

    logic             a_en, b_en;
    oper_sel_t        a_sel, b_sel;
    logic [WIDTH-1:0] a_din, b_din, a_q, b_q;

    bool_t            accept, is_zero, is_ovf, a_neg, b_neg, trial_ok;
    logic [WIDTH:0]   shifted, diff;

    // Dividend register doubles as the quotient shift register during ITER.
    div_operand_reg #(.WIDTH(WIDTH)) u_dividend_reg (
        .clk     (clk),
        .clear_n (resetN),
        .en      (a_en),
        .sel     (a_sel),
        .din     (a_din),
        .q       (a_q)
    );

    div_operand_reg #(.WIDTH(WIDTH)) u_divisor_reg (
        .clk     (clk),
        .clear_n (resetN),
        .en      (b_en),
        .sel     (b_sel),
        .din     (b_din),
        .q       (b_q)
    );

    assign inReady  = (state == IDLE);
    assign outValid = (state == DONE);

    assign accept   = inValid && (state == IDLE) && !flush;
    assign a_neg    = sign_mode && a_q[WIDTH-1];
    assign b_neg    = sign_mode && b_q[WIDTH-1];
    assign is_zero  = (b_q == '0);
    assign is_ovf   = sign_mode && (a_q == MIN_VAL) && (b_q == '1);

    assign shifted  = {rem_w, a_q[WIDTH-1]};
    assign diff     = shifted - {1'b0, b_q};
    assign trial_ok = !diff[WIDTH];

    // State register.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode and operand register controls; flush overrides everything.
    always_comb begin
        state_nxt = state;
        a_en      = 1'b0;
        a_sel     = OPER_IN;
        a_din     = dividend;
        b_en      = 1'b0;
        b_sel     = OPER_IN;
        b_din     = divisor;
        case (state)
            IDLE: begin
                if (accept) begin
                    a_en      = 1'b1;
                    b_en      = 1'b1;
                    state_nxt = PREP;
                end
            end
            PREP: begin
                a_en      = 1'b1;
                a_din     = a_q;
                a_sel     = a_neg ? NEG_OPER_IN : OPER_IN;
                b_en      = 1'b1;
                b_din     = b_q;
                b_sel     = b_neg ? NEG_OPER_IN : OPER_IN;
                state_nxt = (is_zero || is_ovf) ? DONE : ITER;
            end
            ITER: begin
                a_en  = 1'b1;
                a_din = {a_q[WIDTH-2:0], trial_ok};
                if (cnt == '0) begin
                    state_nxt = FIX;
                end
            end
            FIX: begin
                state_nxt = DONE;
            end
            DONE: begin
                if (outReady) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        if (flush) begin
            state_nxt = IDLE;
            a_en      = 1'b0;
            b_en      = 1'b0;
        end
    end

    // Partial remainder, iteration counter, sign bookkeeping and result/flag registers.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            sign_mode <= 1'b0;
            q_neg     <= 1'b0;
            r_neg     <= 1'b0;
            cnt       <= '0;
            rem_w     <= '0;
            quotient  <= '0;
            remainder <= '0;
            divZero   <= 1'b0;
            overflow  <= 1'b0;
        end else if (flush) begin
            divZero  <= 1'b0;
            overflow <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        sign_mode <= signedOp;
                    end
                end
                PREP: begin
                    q_neg <= a_neg ^ b_neg;
                    r_neg <= a_neg;
                    rem_w <= '0;
                    cnt   <= CNT_W'(WIDTH - 1);
                    if (is_zero) begin
                        quotient  <= '1;
                        remainder <= a_q;
                        divZero   <= 1'b1;
                    end else if (is_ovf) begin
                        quotient  <= a_q;
                        remainder <= '0;
                        overflow  <= 1'b1;
                    end
                end
                ITER: begin
                    rem_w <= trial_ok ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end
                end
                FIX: begin
                    quotient  <= q_neg ? -a_q : a_q;
                    remainder <= r_neg ? -rem_w : rem_w;
                end
                DONE: begin
                    if (outReady) begin
                        divZero  <= 1'b0;
                        overflow <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: doc/iter_divider.md
Name: iter_divider

Overview:
Parametrised multi-cycle integer divider that succeeds the fixed 32-bit divider datapath registers. It accepts a dividend/divisor pair over a valid/ready handshake, conditions both operands to magnitudes, and runs one restoring-division step per cycle. It then applies sign correction and holds the quotient/remainder until the consumer accepts them. It sits in the execute stage beside the multiplier and serves both signed and unsigned divide/remainder instructions.

Parameters:
WIDTH, 32, operand/result width in bits (>=4)
CNT_W, $clog2(WIDTH), iteration counter width (derived, not overridden)

Ports:
clk  input  1  rising-edge clock
resetN  input  1  asynchronous active-low reset
inValid  input  1  operands and mode valid
inReady  output  1  block can accept operands
signedOp  input  1  1 = two's-complement operands, 0 = unsigned
dividend  input  WIDTH  numerator
divisor  input  WIDTH  denominator
flush  input  1  synchronous abort of any operation
outValid  output  1  result held valid
outReady  input  1  consumer accepts result
quotient  output  WIDTH  quotient, truncated toward zero
remainder  output  WIDTH  remainder, sign follows dividend
divZero  output  1  divisor was zero
overflow  output  1  signed MIN / -1 occurred

Behaviour:
- Reset (resetN low, async): state IDLE; inReady=1; outValid=0; quotient, remainder, divZero, overflow = 0; all internal registers = 0.
- States: IDLE, PREP, ITER, FIX, DONE.
- IDLE: inReady=1. When inValid&&inReady at an edge, capture dividend, divisor and signedOp, then go to PREP.
- PREP (1 cycle): magnitude mux per operand. Negate when signedOp and MSB=1; otherwise pass through. Record qNeg = signs differ, rNeg = dividend negative (signed only). Load the partial remainder with 0 and the counter with WIDTH-1.
  - Divisor==0: go to DONE with quotient = all ones, remainder = original dividend, divZero=1.
  - signedOp, dividend = 1 followed by zeros, divisor = all ones: go to DONE with quotient = dividend, remainder=0, overflow=1.
  - Otherwise go to ITER.
- ITER: each cycle, shift the {rem, quo} pair left by 1 and trial-subtract the divisor magnitude over WIDTH+1 bits. If the result is non-negative, keep it and set the quotient LSB to 1; otherwise restore. Leave ITER when the counter reaches 0 (exactly WIDTH cycles), then go to FIX.
- FIX (1 cycle): negate quotient if qNeg; negate remainder if rNeg. Go to DONE.
- DONE: outValid=1. Outputs and flags are stable while outReady=0. When outValid&&outReady, go to IDLE, clear outValid and flags, and leave the result registers unchanged.
- inReady=1 only in IDLE. The block never accepts a new operation while busy or while in DONE.
- Latency: the accept edge ends cycle 0; outValid is high in cycle WIDTH+3 (normal) or cycle 2 (zero/overflow path). Throughput is one operation per WIDTH+4 cycles minimum.
- flush: at the next edge, state=IDLE and outValid=0 from any state. flush has priority over inValid in the same cycle, so nothing is accepted on that edge.
- Async reset mid-operation drops all state immediately; no partial result is ever presented.
- Unsigned mode never sets overflow.

Decomposition:
- divider3Pkg holds:
  - state enum (IDLE/PREP/ITER/FIX/DONE)
  - operand mux enum (OPER_IN, NEG_OPER_IN)
  - bool typedef reuse
  - localparam helper for MIN value as a function of WIDTH
- Sub-module div_operand_reg: one parametrised register per operand. It has an enable, a select driven by the operand mux enum, a WIDTH-bit input and an async active-low clear. It is instantiated twice (dividend and divisor magnitudes).
- The FSM, counter and shift/subtract datapath live in the top module.

Test Plan:
- WIDTH=32 unsigned 100/7 -> quotient 14, remainder 2, outValid in cycle 35, flags 0.
- Signed 0xFFFFFF9C(-100)/7 -> quotient 0xFFFFFFF2, remainder 0xFFFFFFFE; signed 100/0xFFFFFFF9(-7) -> quotient 0xFFFFFFF2, remainder 2.
- 5/0 (either mode) -> quotient 0xFFFFFFFF, remainder 5, divZero=1, outValid in cycle 2; signed 0x80000000/0xFFFFFFFF -> quotient 0x80000000, remainder 0, overflow=1; same operands unsigned -> quotient 0, remainder 0x80000000, overflow=0.
- Backpressure: outReady low 5 cycles after outValid -> outputs unchanged and inReady=0 throughout; the cycle after outReady=1, inReady=1 and a queued 9/3 is accepted, giving 3 r 0.
- flush in ITER cycle 10 with inValid high the same cycle -> IDLE next edge, nothing accepted, outValid never rises; a following 0xFFFFFFFF/1 unsigned yields quotient 0xFFFFFFFF, remainder 0.
- resetN pulsed low mid-ITER -> all outputs 0 asynchronously, inReady=1 after release, no stale outValid.
